// File: rtl/stack_pkg.sv
// Constants and FSM state type shared by the 8-deep LIFO stack and its reader.
package stack_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND,
        DONE
    } rd_state_t;

    // Length 0 means "drain everything"; oversize requests saturate at DEPTH.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        if (len == '0 || len > CNT_W'(DEPTH))
            return CNT_W'(DEPTH);
        return len;
    endfunction

endpackage

// File: rtl/stack_drain_reader.sv
// Reader-side controller for the LIFO stack: pops items one at a time and
// streams them out on a valid/ready interface, top of stack first.
module stack_drain_reader
    import stack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_len,
    output logic              stk_pop,
    input  logic [DATA_W-1:0] stk_data,
    input  logic              stk_empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              done,
    output logic [CNT_W-1:0]  done_count,
    output logic              underflow
);

    rd_state_t         state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  len_eff_reg;
    logic              drain_all_reg;
    logic              empty_seen_reg;
    logic              stk_pop_reg;
    logic              m_valid_reg;
    logic [DATA_W-1:0] m_data_reg;
    logic              m_last_reg;
    logic              done_reg;
    logic [CNT_W-1:0]  done_count_reg;
    logic              underflow_reg;
    logic [CNT_W-1:0]  count_next;

    assign count_next = count_reg + CNT_W'(1);

    // The empty flag is captured on the edge that enters ISSUE, so the pop
    // strobe comes straight out of a flop. At that edge the last pop is at
    // least two cycles old and the stack's registered flag has settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            len_eff_reg    <= '0;
            drain_all_reg  <= 1'b0;
            empty_seen_reg <= 1'b0;
            stk_pop_reg    <= 1'b0;
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
            m_last_reg     <= 1'b0;
            done_reg       <= 1'b0;
            done_count_reg <= '0;
            underflow_reg  <= 1'b0;
        end else begin
            stk_pop_reg <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        len_eff_reg    <= eff_len(cmd_len);
                        drain_all_reg  <= (cmd_len == '0);
                        count_reg      <= '0;
                        done_count_reg <= '0;
                        underflow_reg  <= 1'b0;
                        empty_seen_reg <= stk_empty;
                        stk_pop_reg    <= !stk_empty;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (empty_seen_reg) begin
                        underflow_reg  <= !drain_all_reg;
                        done_reg       <= 1'b1;
                        done_count_reg <= count_reg;
                        state_reg      <= DONE;
                    end else begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    m_data_reg  <= stk_data;
                    count_reg   <= count_next;
                    m_valid_reg <= 1'b1;
                    m_last_reg  <= !drain_all_reg && (count_next == len_eff_reg);
                    state_reg   <= SEND;
                end
                SEND: begin
                    if (m_ready) begin
                        m_valid_reg <= 1'b0;
                        m_last_reg  <= 1'b0;
                        if (count_reg == len_eff_reg) begin
                            done_reg       <= 1'b1;
                            done_count_reg <= count_reg;
                            state_reg      <= DONE;
                        end else begin
                            empty_seen_reg <= stk_empty;
                            stk_pop_reg    <= !stk_empty;
                            state_reg      <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = (state_reg == IDLE);
    assign stk_pop    = stk_pop_reg;
    assign m_valid    = m_valid_reg;
    assign m_data     = m_data_reg;
    assign m_last     = m_last_reg;
    assign done       = done_reg;
    assign done_count = done_count_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_stack_drain_reader.sv
// Self-checking bench for stack_drain_reader: behavioural LIFO on the stack
// side, queue-based reference for what each drain command must deliver.
module tb_stack_drain_reader;
    import stack_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_len = '0;
    logic              stk_pop;
    logic [DATA_W-1:0] stk_data = '0;
    logic              stk_empty = 1'b1;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              done;
    logic [CNT_W-1:0]  done_count;
    logic              underflow;

    logic              push_en = 1'b0;
    logic [DATA_W-1:0] push_data = '0;
    logic [DATA_W-1:0] mem [DEPTH];
    int                sp = 0;

    logic [DATA_W-1:0] ref_q [$];
    int                n_checks = 0;
    int                n_pass = 0;

    stack_drain_reader dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .stk_pop    (stk_pop),
        .stk_data   (stk_data),
        .stk_empty  (stk_empty),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .done       (done),
        .done_count (done_count),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // Stack environment: registered data_out and empty flag, pops ignored when empty.
    always @(posedge clk) begin
        if (push_en && sp < DEPTH) begin
            mem[sp]   <= push_data;
            sp        <= sp + 1;
            stk_empty <= 1'b0;
        end else if (stk_pop && sp > 0) begin
            stk_data  <= mem[sp-1];
            sp        <= sp - 1;
            stk_empty <= (sp == 1);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic push(input logic [DATA_W-1:0] d);
        push_en   = 1'b1;
        push_data = d;
        @(negedge clk);
        push_en   = 1'b0;
        ref_q.push_back(d);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall first beat for 4 cycles
    task automatic run_cmd(input int len, input int mode);
        logic [DATA_W-1:0] exp_beats [$];
        logic [DATA_W-1:0] got_beats [$];
        logic              got_last [$];
        int                avail, le, n, stall_left;
        bit                fixed, exp_uf, got_done, prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic              prev_last;
        logic [CNT_W-1:0]  got_cnt;
        logic              got_uf;

        avail = ref_q.size();
        fixed = (len != 0);
        le    = fixed ? len : DEPTH;
        n     = (avail < le) ? avail : le;
        exp_uf = fixed && (avail < le);
        for (int i = 0; i < n; i++)
            exp_beats.push_back(ref_q[avail-1-i]);

        check_eq("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len   = CNT_W'(len);
        @(negedge clk);
        cmd_valid = 1'b0;

        got_done   = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        stall_left = (mode == 2) ? 4 : 0;
        got_cnt    = '0;
        got_uf     = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin
                got_done = 1'b1;
                got_cnt  = done_count;
                got_uf   = underflow;
                break;
            end
            if (prev_stall) begin
                check_eq("stall_valid", m_valid, 1);
                check_eq("stall_data", m_data, prev_data);
                check_eq("stall_last", m_last, prev_last);
            end
            if (m_valid)
                check_eq("no_pop_in_send", stk_pop, 0);
            if (mode == 1)
                m_ready = 1'($urandom_range(0, 1));
            else if (mode == 2 && m_valid && stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else
                m_ready = 1'b1;
            if (m_valid && m_ready) begin
                got_beats.push_back(m_data);
                got_last.push_back(m_last);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            @(negedge clk);
        end

        check_eq("done_seen", got_done, 1);
        check_eq("beat_count", got_beats.size(), n);
        for (int i = 0; i < n && i < got_beats.size(); i++) begin
            check_eq("beat_data", got_beats[i], exp_beats[i]);
            check_eq("beat_last", got_last[i], fixed && (i == n - 1) && (n == le));
        end
        check_eq("done_count", got_cnt, n);
        check_eq("underflow", got_uf, exp_uf);
        $display("cmd len=%0d mode=%0d avail=%0d beats=%0d done_count=%0d underflow=%0d",
                 len, mode, avail, got_beats.size(), got_cnt, got_uf);

        m_ready = 1'b0;
        @(negedge clk);
        check_eq("done_pulse_end", done, 0);
        check_eq("done_count_hold", done_count, n);
        check_eq("underflow_hold", underflow, exp_uf);
        for (int i = 0; i < n; i++)
            void'(ref_q.pop_back());
    endtask

    initial begin
        int k;
        bit seen;

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_stk_pop", stk_pop, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_done_count", done_count, 0);
        check_eq("rst_underflow", underflow, 0);

        // Fixed length shorter than contents
        push(8'd11); push(8'd22); push(8'd33);
        run_cmd(2, 0);
        check_eq("leftover_not_empty", stk_empty, 0);

        // Drain all
        push(8'd44); push(8'd55);
        run_cmd(0, 0);
        check_eq("drained_empty", stk_empty, 1);

        // Underflow
        push(8'd66); push(8'd77);
        run_cmd(5, 0);

        // Backpressure
        push(8'd81); push(8'd82); push(8'd83);
        run_cmd(3, 2);

        // Reset while a beat is waiting in SEND
        push(8'd91); push(8'd92); push(8'd93); push(8'd94);
        m_ready   = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = CNT_W'(3);
        @(negedge clk);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("rst_test_valid_seen", seen, 1);
        check_eq("rst_test_top_beat", m_data, ref_q[ref_q.size()-1]);
        void'(ref_q.pop_back());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_m_valid", m_valid, 0);
        check_eq("midrst_cmd_ready", cmd_ready, 1);
        check_eq("midrst_done", done, 0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            check_eq("midrst_no_pop", stk_pop, 0);
            @(negedge clk);
        end
        run_cmd(0, 1);
        check_eq("after_rst_empty", stk_empty, 1);

        // Randomized commands, including drains of an empty stack
        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, DEPTH - ref_q.size());
            for (int j = 0; j < k; j++)
                push(8'($urandom));
            run_cmd($urandom_range(0, DEPTH), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
